if_fetch_unit: RTL and testbench

Instruction fetch front-end. Consumes the current PC from the PC register and issues instruction-memory read requests at that address. It returns Adv to the PC register so the PC advances only when a fetch completes. Fetched {pc, instr} pairs are buffered in a small FIFO toward decode, with support for flush/redirect and sticky halt.

---
 rtl/cpu_types_pkg.sv | 20 ++
 rtl/if_fetch_unit_fifo.sv | 86 ++++++++
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types used by the instruction fetch front-end.
// Holds the machine word type, the fetch FSM states and the layout
// of one buffered {pc, instr} fetch entry.
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        word_t pc;
        word_t instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_fetch_unit_fifo.sv
// Instruction buffer between fetch and decode.
// Power-of-two ring buffer with registered storage; the head entry is
// presented combinationally. A push while full is accepted only when a
// pop happens in the same cycle. 'clear' empties the buffer and wins
// over any push or pop in that cycle.
module if_inst_fifo
    import cpu_types_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         empty,
    output logic         full
);

    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [BUF_DEPTH];
    logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
    logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             doPush;
    logic             doPop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CNT_W'(BUF_DEPTH));
    assign rdata = mem_q[rdPtr_q];

    // Next pointer/occupancy values; pointers wrap naturally at BUF_DEPTH
    always_comb begin
        doPop   = pop & ~empty;
        doPush  = push & (~full | doPop);
        rdPtr_d = rdPtr_q;
        wrPtr_d = wrPtr_q;
        count_d = count_q;
        if (clear) begin
            rdPtr_d = '0;
            wrPtr_d = '0;
            count_d = '0;
        end else begin
            if (doPush) begin
                wrPtr_d = wrPtr_q + PTR_W'(1);
            end
            if (doPop) begin
                rdPtr_d = rdPtr_q + PTR_W'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rdPtr_q <= '0;
            wrPtr_q <= '0;
            count_q <= '0;
        end else begin
            rdPtr_q <= rdPtr_d;
            wrPtr_q <= wrPtr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; zeroed on reset so the head reads as zero afterwards
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (doPush && !clear) begin
            mem_q[wrPtr_q] <= wdata;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front-end.
// Issues instruction-memory reads at the current PC, tells the PC
// register to advance only when a read completes (or on a redirect),
// and buffers fetched {pc, instr} pairs toward decode. A decoded halt
// stops fetching until reset while the buffer keeps draining.
// Optional build macro IF_PERF_CNT_EN adds saturating fetch/stall
// performance counters as extra output ports.
module if_fetch_unit
    import cpu_types_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    parameter int CNT_W     = 32
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] PC,
    output logic        Adv,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        ihit,
    input  logic [31:0] iload,
    input  logic        flush,
    input  logic        halt,
    output logic        inst_valid,
    output logic [31:0] instr,
    output logic [31:0] inst_pc,
    input  logic        dec_ready
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] fetch_cnt,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    fetch_state_t state_q, state_d;
    fetch_entry_t fifoWdata;
    fetch_entry_t fifoRdata;
    logic         fifoEmpty;
    logic         fifoFull;
    logic         fifoPush;
    logic         fifoPop;
    logic         pop;
    logic         canPush;

    assign iaddr      = PC;
    assign inst_valid = ~fifoEmpty;
    assign instr      = fifoRdata.instr;
    assign inst_pc    = fifoRdata.pc;
    assign pop        = inst_valid & dec_ready;
    assign canPush    = ~fifoFull | pop;
    assign fifoWdata  = '{pc: PC, instr: iload};

    // Request/advance control and next state; flush outranks halt and hits
    always_comb begin
        iREN     = 1'b0;
        Adv      = 1'b0;
        fifoPush = 1'b0;
        fifoPop  = pop & ~flush;
        state_d  = state_q;
        if (nRST) begin
            case (state_q)
                FETCH: begin
                    if (flush) begin
                        Adv = 1'b1;
                    end else if (halt) begin
                        state_d = HALTED;
                    end else begin
                        iREN = canPush;
                        if (canPush && ihit) begin
                            fifoPush = 1'b1;
                            Adv      = 1'b1;
                        end
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Fetch FSM state register; HALTED is left only through reset
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    if_inst_fifo #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_fifo (
        .CLK   (CLK),
        .nRST  (nRST),
        .clear (flush),
        .push  (fifoPush),
        .pop   (fifoPop),
        .wdata (fifoWdata),
        .rdata (fifoRdata),
        .empty (fifoEmpty),
        .full  (fifoFull)
    );

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetchCnt_q, fetchCnt_d;
    logic [CNT_W-1:0] stallCnt_q, stallCnt_d;
    logic             stallCond;

    assign fetch_cnt = fetchCnt_q;
    assign stall_cnt = stallCnt_q;

    // Saturating counts of pushes and of cycles spent waiting to fetch
    always_comb begin
        stallCond  = (state_q == FETCH) & ~halt & ~flush & (~canPush | (iREN & ~ihit));
        fetchCnt_d = fetchCnt_q;
        stallCnt_d = stallCnt_q;
        if (fifoPush && (fetchCnt_q != '1)) begin
            fetchCnt_d = fetchCnt_q + CNT_W'(1);
        end
        if (stallCond && (stallCnt_q != '1)) begin
            stallCnt_d = stallCnt_q + CNT_W'(1);
        end
    end

    // Counter registers; only reset clears them
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fetchCnt_q <= '0;
            stallCnt_q <= '0;
        end else begin
            fetchCnt_q <= fetchCnt_d;
            stallCnt_q <= stallCnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit.
// The bench plays the PC register and instruction memory. A reference
// model decides each cycle which fetches complete and queues the
// expected {pc, instr} pairs; an independent monitor compares the
// buffer head against that queue whenever decode could consume it.
module tb_if_fetch_unit;
    import cpu_types_pkg::*;

    localparam int BUF_DEPTH = 2;
    localparam int CNT_W     = 32;

    logic        CLK;
    logic        nRST;
    logic [31:0] PC;
    logic        Adv;
    logic        iREN;
    logic [31:0] iaddr;
    logic        ihit;
    logic [31:0] iload;
    logic        flush;
    logic        halt;
    logic        inst_valid;
    logic [31:0] instr;
    logic [31:0] inst_pc;
    logic        dec_ready;
`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt;
    logic [CNT_W-1:0] stall_cnt;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] expQ[$];
    word_t       pcReg;
    bit          halted;
    int          expFetch;
    int          expStall;

    if_fetch_unit #(
        .BUF_DEPTH (BUF_DEPTH),
        .CNT_W     (CNT_W)
    ) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .PC         (PC),
        .Adv        (Adv),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .ihit       (ihit),
        .iload      (iload),
        .flush      (flush),
        .halt       (halt),
        .inst_valid (inst_valid),
        .instr      (instr),
        .inst_pc    (inst_pc),
        .dec_ready  (dec_ready)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_cnt  (fetch_cnt),
        .stall_cnt  (stall_cnt)
`endif
    );

    // Free-running clock, 10 time-unit period
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Hold reset for one cycle with the given ihit, check the cleared outputs
    task automatic doReset(input logic hit);
        @(negedge CLK);
        nRST      = 1'b0;
        ihit      = hit;
        iload     = $urandom();
        flush     = 1'b0;
        halt      = 1'b0;
        dec_ready = 1'b1;
        #2;
        checkOutput("reset iREN", 32'(iREN), 32'd0);
        checkOutput("reset inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("reset instr", instr, 32'd0);
        checkOutput("reset inst_pc", inst_pc, 32'd0);
`ifdef IF_PERF_CNT_EN
        checkOutput("reset fetch_cnt", 32'(fetch_cnt), 32'd0);
        checkOutput("reset stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        expQ.delete();
        pcReg    = 32'h0;
        halted   = 1'b0;
        expFetch = 0;
        expStall = 0;
    endtask

    // One clock of stimulus; checks combinational outputs and steps the model
    task automatic applyStimulus(input logic hit, input logic ready, input logic fl,
                                 input logic hl, input word_t target);
        logic  expIren;
        logic  expAdv;
        logic  room;
        word_t word;
        @(negedge CLK);
        nRST      = 1'b1;
        PC        = pcReg;
        ihit      = hit;
        word      = $urandom();
        iload     = word;
        dec_ready = ready;
        flush     = fl;
        halt      = hl;
        #2;
        // The monitor has already retired this cycle's pop from expQ
        expIren = 1'b0;
        expAdv  = 1'b0;
        if (halted) begin
            if (fl) expQ.delete();
        end else if (fl) begin
            expAdv = 1'b1;
            expQ.delete();
            pcReg = target;
        end else if (hl) begin
            halted = 1'b1;
        end else begin
            room    = (expQ.size() < BUF_DEPTH);
            expIren = room;
            if (room && hit) begin
                expAdv = 1'b1;
                expQ.push_back({pcReg, word});
                pcReg = pcReg + 32'd4;
            end
        end
        checkOutput("iREN", 32'(iREN), 32'(expIren));
        checkOutput("Adv", 32'(Adv), 32'(expAdv));
        checkOutput("iaddr", iaddr, PC);
`ifdef IF_PERF_CNT_EN
        checkOutput("fetch_cnt", 32'(fetch_cnt), 32'(expFetch));
        checkOutput("stall_cnt", 32'(stall_cnt), 32'(expStall));
        if (expAdv && !fl) expFetch++;
        if (!halted && !hl && !fl && !(expIren && hit)) expStall++;
`endif
    endtask

    // Monitor: compares the buffer head with the oldest expected entry
    initial begin
        forever begin
            @(negedge CLK);
            #1;
            if (nRST) begin
                checkOutput("inst_valid", 32'(inst_valid), 32'(expQ.size() != 0));
                if (expQ.size() != 0) begin
                    checkOutput("inst_pc", inst_pc, expQ[0][63:32]);
                    checkOutput("instr", instr, expQ[0][31:0]);
                    if (dec_ready && !flush) void'(expQ.pop_front());
                end
            end
        end
    end

    // Directed scenarios followed by randomized traffic
    initial begin
        nRST      = 1'b0;
        PC        = 32'h0;
        ihit      = 1'b0;
        iload     = 32'h0;
        flush     = 1'b0;
        halt      = 1'b0;
        dec_ready = 1'b0;
        pcReg     = 32'h0;
        halted    = 1'b0;
        expFetch  = 0;
        expStall  = 0;

        doReset(1'b0);

        // Back-to-back hits from PC 0
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // Redirect to 0x100, then three wait states before the hit
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 32'h100);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);

        // Decode stalled: buffer fills, then one pop frees room for one push
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);

        // Flush with a full buffer and a hit, resume at 0x200
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h200);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // Randomized traffic with occasional redirects
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 7),
                          ($urandom_range(0, 19) == 0), 1'b0,
                          word_t'($urandom() & 32'hFFFF_FFFC));
        end

        // flush+halt together stays in FETCH; buffer one entry; then halt
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h400);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 32'h500);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);

        // Reset mid-request: wait states then reset while ihit is high
        doReset(1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        doReset(1'b1);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(($urandom_range(0, 9) < 5), ($urandom_range(0, 9) < 6),
                          ($urandom_range(0, 29) == 0), 1'b0,
                          word_t'($urandom() & 32'hFFFF_FFFC));
        end

        @(negedge CLK);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
